// File: rtl/lif_pkg.sv
// Shared state type, constants and saturating arithmetic helpers for the LIF neuron core.
package lif_pkg;

    localparam int unsigned DECAY_FRAC = 16;
    localparam int          RST_ZERO   = 0;
    localparam int          RST_SUB    = 1;
    localparam int unsigned SAT_W      = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAK  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_FIRE  = 2'd3
    } lif_state_t;

    typedef logic signed [SAT_W-1:0] sat_t;
    typedef logic signed [SAT_W:0]   sat_wide_t;

    // Clamp a wide signed value into the signed range of 'width' bits (width < SAT_W).
    function automatic sat_t sat_clamp(input sat_wide_t x, input int unsigned width);
        sat_wide_t max_v;
        sat_wide_t min_v;
        sat_t      res;
        max_v = (sat_wide_t'(1) <<< (width - 1)) - sat_wide_t'(1);
        min_v = ~max_v;
        if (x > max_v) begin
            res = max_v[SAT_W-1:0];
        end else if (x < min_v) begin
            res = min_v[SAT_W-1:0];
        end else begin
            res = x[SAT_W-1:0];
        end
        return res;
    endfunction

    function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned width);
        sat_wide_t s;
        s = sat_wide_t'(a) + sat_wide_t'(b);
        return sat_clamp(s, width);
    endfunction

    function automatic sat_t sat_sub(input sat_t a, input sat_t b, input int unsigned width);
        sat_wide_t s;
        s = sat_wide_t'(a) - sat_wide_t'(b);
        return sat_clamp(s, width);
    endfunction

endpackage

// File: rtl/lif_leak_mult.sv
// Registered signed x unsigned Q0.16 leak multiply with arithmetic shift and saturation.
module lif_leak_mult
    import lif_pkg::*;
#(
    parameter int POT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [POT_WIDTH-1:0]  v_in,
    input  logic [DECAY_FRAC-1:0] decay,
    output logic [POT_WIDTH-1:0]  v_out
);

    localparam int PROD_W = POT_WIDTH + DECAY_FRAC + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic [POT_WIDTH-1:0]     v_out_d;
    logic [POT_WIDTH-1:0]     v_out_q;

    always_comb begin
        prod    = PROD_W'($signed(v_in)) * PROD_W'($signed({1'b0, decay}));
        // Arithmetic shift floors toward -inf for negative potentials.
        shifted = prod >>> DECAY_FRAC;
        v_out_d = v_out_q;
        if (en) begin
            v_out_d = POT_WIDTH'(sat_clamp(sat_wide_t'(shifted), POT_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_out_q <= '0;
        end else begin
            v_out_q <= v_out_d;
        end
    end

    assign v_out = v_out_q;

endmodule

// File: rtl/lif_layer_core.sv
// Leaky integrate-and-fire neuron with NUM_INPUTS synapses processed one per cycle per step.
module lif_layer_core
    import lif_pkg::*;
#(
    parameter int NUM_INPUTS    = 8,
    parameter int WEIGHT_WIDTH  = 16,
    parameter int POT_WIDTH     = 24,
    parameter int REFRACT_WIDTH = 4,
    parameter int RESET_MODE    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               step_valid,
    output logic                               step_ready,
    input  logic [NUM_INPUTS-1:0]              spikes_in,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weight_flat,
    input  logic [15:0]                        decay_val,
    input  logic [POT_WIDTH-1:0]               thresh_val,
    input  logic [REFRACT_WIDTH-1:0]           refract_val,
    output logic                               out_valid,
    output logic                               spike_out,
    output logic [POT_WIDTH-1:0]               membrane_out,
    output logic [15:0]                        spike_count
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    lif_state_t                state_q, state_d;
    logic [NUM_INPUTS-1:0]     spikes_q, spikes_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [POT_WIDTH-1:0] v_q, v_d;
    logic [REFRACT_WIDTH-1:0]  r_q, r_d;
    logic                      refr_q, refr_d;
    logic                      spike_q, spike_d;
    logic [POT_WIDTH-1:0]      membrane_q, membrane_d;
    logic [15:0]               count_q, count_d;
    logic                      out_valid_q, out_valid_d;

    logic [POT_WIDTH-1:0]        leak_v;
    logic signed [POT_WIDTH-1:0] accum_base;
    logic signed [WEIGHT_WIDTH-1:0] w_sel;
    logic signed [POT_WIDTH-1:0] acc_sum;
    logic signed [POT_WIDTH-1:0] sub_res;
    logic signed [POT_WIDTH-1:0] thresh_s;
    logic                        fire;

    lif_leak_mult #(
        .POT_WIDTH(POT_WIDTH)
    ) u_leak (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_LEAK),
        .v_in  (v_q),
        .decay (decay_val),
        .v_out (leak_v)
    );

    assign step_ready = (state_q == ST_IDLE) && enable;
    assign thresh_s   = thresh_val;

    always_comb begin
        state_d     = state_q;
        spikes_d    = spikes_q;
        idx_d       = idx_q;
        v_d         = v_q;
        r_d         = r_q;
        refr_d      = refr_q;
        spike_d     = spike_q;
        membrane_d  = membrane_q;
        count_d     = count_q;
        out_valid_d = 1'b0;

        // The leak result lands in the multiplier register, so synapse 0 builds on it directly.
        accum_base = (idx_q == '0) ? leak_v : v_q;
        w_sel      = weight_flat[32'(idx_q) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        acc_sum    = POT_WIDTH'(sat_add(sat_t'(accum_base), sat_t'(w_sel), POT_WIDTH));
        sub_res    = POT_WIDTH'(sat_sub(sat_t'(v_q), sat_t'(thresh_s), POT_WIDTH));
        fire       = !refr_q && (v_q >= thresh_s);

        case (state_q)
            ST_IDLE: begin
                if (step_valid && step_ready) begin
                    spikes_d = spikes_in;
                    idx_d    = '0;
                    refr_d   = (r_q != '0);
                    state_d  = ST_LEAK;
                end
            end
            ST_LEAK: begin
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (refr_q) begin
                    v_d = '0;
                end else if (spikes_q[idx_q]) begin
                    v_d = acc_sum;
                end else begin
                    v_d = accum_base;
                end
                if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_FIRE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_FIRE: begin
                if (fire) begin
                    spike_d = 1'b1;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    r_d     = refract_val;
                    v_d     = (RESET_MODE == RST_SUB) ? sub_res : '0;
                end else begin
                    spike_d = 1'b0;
                    if (refr_q) begin
                        r_d = r_q - REFRACT_WIDTH'(1);
                    end
                end
                membrane_d  = v_d;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            spikes_q    <= '0;
            idx_q       <= '0;
            v_q         <= '0;
            r_q         <= '0;
            refr_q      <= 1'b0;
            spike_q     <= 1'b0;
            membrane_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            spikes_q    <= spikes_d;
            idx_q       <= idx_d;
            v_q         <= v_d;
            r_q         <= r_d;
            refr_q      <= refr_d;
            spike_q     <= spike_d;
            membrane_q  <= membrane_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign spike_out    = spike_q;
    assign membrane_out = membrane_q;
    assign spike_count  = count_q;

endmodule

// File: tb/tb_lif_layer_core.sv
// Scoreboard bench for lif_layer_core: three configurations driven with hand-computed vectors.
module tb_lif_layer_core;

    localparam int N = 4;

    typedef struct {
        int   cyc;
        logic sp;
        int   mem;
        int   cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic [2:0]    sv;
    logic [N-1:0]  spikes;
    logic [N*16-1:0] wflat;
    logic [15:0]   decay;
    logic [23:0]   thresh24;
    logic [15:0]   thresh16;
    logic [3:0]    refract;

    logic [2:0]    ready;
    logic [2:0]    ov;
    logic [2:0]    so;
    logic [23:0]   mem0, mem1;
    logic [15:0]   mem2;
    logic [15:0]   cnt0, cnt1, cnt2;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    lif_layer_core #(.NUM_INPUTS(N), .WEIGHT_WIDTH(16), .POT_WIDTH(24), .REFRACT_WIDTH(4), .RESET_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .step_valid(sv[0]), .step_ready(ready[0]),
        .spikes_in(spikes), .weight_flat(wflat), .decay_val(decay), .thresh_val(thresh24),
        .refract_val(refract), .out_valid(ov[0]), .spike_out(so[0]), .membrane_out(mem0),
        .spike_count(cnt0));

    lif_layer_core #(.NUM_INPUTS(N), .WEIGHT_WIDTH(16), .POT_WIDTH(24), .REFRACT_WIDTH(4), .RESET_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .step_valid(sv[1]), .step_ready(ready[1]),
        .spikes_in(spikes), .weight_flat(wflat), .decay_val(decay), .thresh_val(thresh24),
        .refract_val(refract), .out_valid(ov[1]), .spike_out(so[1]), .membrane_out(mem1),
        .spike_count(cnt1));

    lif_layer_core #(.NUM_INPUTS(N), .WEIGHT_WIDTH(16), .POT_WIDTH(16), .REFRACT_WIDTH(4), .RESET_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .step_valid(sv[2]), .step_ready(ready[2]),
        .spikes_in(spikes), .weight_flat(wflat), .decay_val(decay), .thresh_val(thresh16),
        .refract_val(refract), .out_valid(ov[2]), .spike_out(so[2]), .membrane_out(mem2),
        .spike_count(cnt2));

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_out(input int d, input logic act_sp, input int act_mem, input int act_cnt);
        exp_t e;
        logic have;
        have = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        tests++;
        if (!have) begin
            fails++;
            $display("FAIL unexpected_out_valid dut%0d cyc=%0d: got spike=%0b mem=%0d cnt=%0d, expected no output",
                     d, cyc, act_sp, act_mem, act_cnt);
        end else if (e.cyc != cyc || e.sp !== act_sp || e.mem != act_mem || e.cnt != act_cnt) begin
            fails++;
            $display("FAIL step_result dut%0d: got cyc=%0d spike=%0b mem=%0d cnt=%0d, expected cyc=%0d spike=%0b mem=%0d cnt=%0d",
                     d, cyc, act_sp, act_mem, act_cnt, e.cyc, e.sp, e.mem, e.cnt);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ov[0]) check_out(0, so[0], int'($signed(mem0)), int'(cnt0));
            if (ov[1]) check_out(1, so[1], int'($signed(mem1)), int'(cnt1));
            if (ov[2]) check_out(2, so[2], int'($signed(mem2)), int'(cnt2));
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called at a negedge with the target core idle; returns at the negedge where out_valid is due,
    // so consecutive calls issue steps back-to-back.
    task automatic run(input int d, input logic [N-1:0] sp, input logic esp, input int emem, input int ecnt);
        exp_t e;
        spikes = sp;
        sv[d]  = 1'b1;
        @(posedge clk);
        #1;
        sv[d]  = 1'b0;
        e.cyc  = cyc + 6;
        e.sp   = esp;
        e.mem  = emem;
        e.cnt  = ecnt;
        push(d, e);
        repeat (7) @(negedge clk);
    endtask

    localparam logic [N*16-1:0] W_BASE = {16'hFFF6, 16'd20, 16'd30, 16'd40};

    initial begin
        exp_t e;
        rst      = 1'b1;
        enable   = 1'b1;
        sv       = '0;
        spikes   = '0;
        wflat    = W_BASE;
        decay    = 16'h8000;
        thresh24 = 24'd100;
        thresh16 = 16'd100;
        refract  = 4'd0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready0", int'(ready[0]), 1);
        chk("reset_ready2", int'(ready[2]), 1);
        chk("reset_outvalid", int'(ov), 0);
        chk("reset_spike", int'(so), 0);
        chk("reset_mem0", int'(mem0), 0);
        chk("reset_mem1", int'(mem1), 0);
        chk("reset_cnt0", int'(cnt0), 0);
        chk("reset_cnt2", int'(cnt2), 0);

        // Basic integrate and fire, reset-to-zero.
        run(0, 4'b0111, 1'b0, 90, 0);
        run(0, 4'b0111, 1'b1, 0, 1);
        // Subtract-threshold mode, back-to-back.
        run(1, 4'b0111, 1'b0, 90, 0);
        run(1, 4'b0111, 1'b1, 35, 1);

        // Refractory period of two steps.
        refract = 4'd2;
        run(0, 4'b0111, 1'b0, 90, 1);
        run(0, 4'b0111, 1'b1, 0, 2);
        refract = 4'd0;
        run(0, 4'b1111, 1'b0, 0, 2);
        run(0, 4'b1111, 1'b0, 0, 2);
        run(0, 4'b1111, 1'b0, 80, 2);

        // Leak rounding, including negative potentials flooring toward -inf.
        run(0, 4'b1000, 1'b0, 30, 2);
        run(0, 4'b1000, 1'b0, 5, 2);
        run(0, 4'b1000, 1'b0, -8, 2);
        run(0, 4'b1000, 1'b0, -14, 2);
        run(0, 4'b1000, 1'b0, -17, 2);
        run(0, 4'b1000, 1'b0, -19, 2);
        decay = 16'hFFFF;
        run(0, 4'b0000, 1'b0, -19, 2);
        decay = 16'h0000;
        run(0, 4'b0001, 1'b0, 40, 2);
        decay = 16'h8000;

        // Enable dropped mid-step and a step_valid pulse while busy: step completes, pulse ignored.
        spikes = 4'b0110;
        sv[0]  = 1'b1;
        @(posedge clk);
        #1;
        sv[0]  = 1'b0;
        e.cyc = cyc + 6; e.sp = 1'b0; e.mem = 70; e.cnt = 2;
        push(0, e);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        spikes = 4'b1111;
        sv[0]  = 1'b1;
        @(negedge clk);
        sv[0]  = 1'b0;
        repeat (4) @(negedge clk);
        chk("ready_low_enable0", int'(ready[0]), 0);

        // step_valid held with enable low: nothing accepted.
        sv[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("ready_low_held", int'(ready[0]), 0);
        sv[0]  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("ready_back_high", int'(ready[0]), 1);

        // Threshold equality fires.
        thresh24 = 24'd105;
        run(0, 4'b0011, 1'b1, 0, 3);
        thresh24 = 24'd100;
        run(0, 4'b0111, 1'b0, 90, 3);

        // 16-bit potential: positive and negative saturation.
        wflat    = {4{16'h7FFF}};
        thresh16 = 16'h7FFF;
        run(2, 4'b1111, 1'b1, 0, 1);
        wflat    = {4{16'h8000}};
        run(2, 4'b1111, 1'b0, -32768, 1);
        run(2, 4'b0000, 1'b0, -16384, 1);
        wflat    = W_BASE;

        // Reset in the middle of a step drops it and clears all state.
        spikes = 4'b0111;
        sv[0]  = 1'b1;
        @(posedge clk);
        #1;
        sv[0]  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", int'(ready[0]), 1);
        chk("midrst_outvalid", int'(ov[0]), 0);
        chk("midrst_mem0", int'(mem0), 0);
        chk("midrst_cnt0", int'(cnt0), 0);
        chk("midrst_cnt1", int'(cnt1), 0);
        repeat (10) @(negedge clk);
        run(0, 4'b0111, 1'b0, 90, 0);
        run(1, 4'b0111, 1'b0, 90, 0);
        thresh16 = 16'd100;
        run(2, 4'b0001, 1'b0, 40, 0);

        repeat (10) @(negedge clk);
        chk("pending_dut0", q0.size(), 0);
        chk("pending_dut1", q1.size(), 0);
        chk("pending_dut2", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lif_layer_core.md
Name: lif_layer_core

Overview:
- Parametrised successor to the single-input LIF neuron datapath: one leaky integrate-and-fire neuron with NUM_INPUTS synapses.
- Each accepted time step is processed sequentially: leak, weighted accumulation of the input spike vector (one synapse per cycle), then threshold/fire.
- Adds a selectable reset mode, a refractory period, saturating arithmetic, a valid/ready step handshake and a spike counter.
- Sits between the Poisson encoder bank, which provides spikes_in, and the next layer or spike sink.

Parameters:
- NUM_INPUTS, 8: number of synapses; must be ≥1.
- WEIGHT_WIDTH, 16: signed weight width.
- POT_WIDTH, 24: signed membrane-potential and threshold width; must be ≥ WEIGHT_WIDTH.
- REFRACT_WIDTH, 4: width of the refractory period, counted in time steps.
- RESET_MODE, 0: 0 = reset potential to zero on fire; 1 = subtract threshold on fire.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  permits acceptance of new steps
- step_valid  in  1  spikes_in is valid
- step_ready  out  1  core is idle and enable=1
- spikes_in  in  NUM_INPUTS  spike vector for one time step
- weight_flat  in  NUM_INPUTS*WEIGHT_WIDTH  signed weights; weight i is at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; must be held stable while busy
- decay_val  in  16  unsigned Q0.16 leak factor
- thresh_val  in  POT_WIDTH  signed firing threshold
- refract_val  in  REFRACT_WIDTH  refractory steps after a fire
- out_valid  out  1  one-cycle pulse: step result is available
- spike_out  out  1  fire result of the last step; held until the next out_valid
- membrane_out  out  POT_WIDTH  membrane potential after the last step
- spike_count  out  16  number of fires, saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs and internal state are 0, including potential V, refractory counter R and spike_count; state = IDLE.
- Reset mid-operation: the next cycle is in IDLE with all state cleared; the in-flight step is dropped and no out_valid is produced.
- FSM: IDLE -> LEAK -> ACCUM -> FIRE -> IDLE.
- step_ready = (state==IDLE) & enable, combinational.
- A step is accepted when step_valid & step_ready; spikes_in is registered in that cycle.
- step_valid is ignored while busy or while enable=0. Deasserting enable mid-step does not abort the step.
- LEAK (1 cycle): V <= (V * decay_val) >>> 16. The product is signed, POT_WIDTH+17 bits; the shift is arithmetic (rounds toward -inf).
- ACCUM (NUM_INPUTS cycles, index i = 0..NUM_INPUTS-1): if spike[i]=1, V <= sat(V + sext(weight[i])).
  - sat clamps to the signed range of POT_WIDTH, both positive and negative.
- FIRE (1 cycle):
  - If V >= thresh_val (signed compare): spike_out <= 1; spike_count increments; R <= refract_val.
  - On fire, V <= 0 when RESET_MODE=0, or V <= sat(V - thresh_val) when RESET_MODE=1.
  - Otherwise spike_out <= 0.
  - membrane_out <= new V.
- Refractory: if R != 0 at acceptance, the step still walks LEAK/ACCUM/FIRE with constant latency, but:
  - V is forced to 0 and inputs are ignored;
  - no fire occurs; spike_out = 0;
  - R decrements in FIRE.
- Latency: acceptance in cycle 0, LEAK in cycle 1, ACCUM in cycles 2..NUM_INPUTS+1, FIRE in cycle NUM_INPUTS+2.
  - out_valid = 1 in cycle NUM_INPUTS+3, with step_ready high in that same cycle (if enable=1).
  - Throughput: one step per NUM_INPUTS+3 cycles.
- No output backpressure: out_valid is a pulse and the consumer must sample it.
- thresh_val, decay_val and refract_val are sampled live in their respective states.

Decomposition:
- Package lif_pkg holds:
  - state enum typedef lif_state_t;
  - reset-mode constants RST_ZERO=0 and RST_SUB=1;
  - saturating add/sub functions parametrised by width;
  - the DECAY_FRAC=16 constant.
- One sub-module, lif_leak_mult: registered signed × Q0.16 multiply with arithmetic shift and saturation. It isolates the multiplier for DSP mapping.

Test Plan (NUM_INPUTS=4, weights 40/30/20/-10, decay_val=16'h8000, thresh_val=100, refract_val=0, RESET_MODE=0 unless stated):
- Step spikes 4'b0111 from V=0 -> out_valid in cycle 7, spike_out=0, membrane_out=90. A second identical step -> 45+90=135 fires: spike_out=1, membrane_out=0, spike_count=1.
- RESET_MODE=1, same two steps -> second step spike_out=1, membrane_out=35.
- refract_val=2, fire, then three steps with 4'b1111 -> first two give spike_out=0, membrane_out=0; third gives membrane_out=80, no fire.
- POT_WIDTH=16, all weights 16'h7FFF, thresh_val=16'h7FFF, spikes 4'b1111 -> membrane saturates to 32767, fires.
- All weights 16'h8000 with spikes 4'b1111 -> membrane_out=-32768, no wrap.
- Assert rst in cycle 3 of a step -> next cycle state is IDLE, membrane_out=0, spike_count=0, no out_valid, step_ready=1.
- Handshake checks:
  - step_valid held with enable=0 -> no acceptance, no out_valid.
  - step_valid pulsed while busy -> ignored.
  - Back-to-back steps -> accepted exactly every 7 cycles.
